// File: rtl/tmp_regfile_rob_if.sv
// rtl/tmp_regfile_rob_if.sv - dispatch/CDB/commit/read bundle for the speculative register file
interface tmp_regfile_rob_if #(
    parameter int DEPTH   = 32,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int REG_W   = 5,
    parameter int NRD     = 2,
    parameter int AW      = $clog2(DEPTH),
    parameter int ENTRY_W = REG_W + PC_W + 2 + DATA_W + 2
);
    logic                   flush;

    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [ENTRY_W-1:0]     alloc_data;
    logic [AW-1:0]          alloc_tag;

    logic                   upd_valid;
    logic [AW-1:0]          upd_tag;
    logic [DATA_W-1:0]      upd_data;

    logic                   commit_valid;
    logic                   commit_ready;
    logic [AW-1:0]          commit_tag;
    logic [ENTRY_W-1:0]     commit_data;

    logic [NRD*AW-1:0]      rd_tag;
    logic [NRD*ENTRY_W-1:0] rd_data;

    logic [AW:0]            count;
    logic                   full;
    logic                   empty;

    modport master (
        output flush, alloc_valid, alloc_data, upd_valid, upd_tag, upd_data,
               commit_ready, rd_tag,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_data,
               rd_data, count, full, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_data, upd_valid, upd_tag, upd_data,
               commit_ready, rd_tag,
        output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_data,
               rd_data, count, full, empty
    );
endinterface

// File: rtl/tmp_regfile_rob.sv
// rtl/tmp_regfile_rob.sv - circular tag-indexed speculative register file, optional read bypass via TMPRF_BYPASS_EN
module tmp_regfile_rob #(
    parameter int DEPTH   = 32,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int REG_W   = 5,
    parameter int NRD     = 2,
    parameter int AW      = $clog2(DEPTH),
    parameter int ENTRY_W = REG_W + PC_W + 2 + DATA_W + 2
) (
    input  logic              clock,
    input  logic              reset,
    tmp_regfile_rob_if.slave  bus
);
    // Entry layout, LSB side: valid at bit 0, spec_valid at bit 1, spec_data above them.
    localparam int SD_LSB = 2;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [AW:0]        count_q;

    logic               full_w;
    logic               head_ready;
    logic               alloc_fire;
    logic               upd_fire;
    logic               commit_fire;
    logic [ENTRY_W-1:0] head_entry;

    // The two low alloc_data bits are replaced by the valid/spec_valid flags.
    logic               unused_alloc_bits;
    assign unused_alloc_bits = ^bus.alloc_data[1:0];

    assign head_entry  = mem[head];
    assign full_w      = (count_q == (AW+1)'(DEPTH));
    assign head_ready  = head_entry[1] & head_entry[0];

    // Full blocks alloc even if a commit frees a slot in the same cycle.
    assign alloc_fire  = bus.alloc_valid & ~full_w;
    // An update only lands on a live entry; alloc targets are never live, so alloc wins.
    assign upd_fire    = bus.upd_valid & mem[bus.upd_tag][0];
    assign commit_fire = head_ready & bus.commit_ready;

    // Storage and pointer state; flush outranks every other operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (upd_fire) begin
                mem[bus.upd_tag][SD_LSB +: DATA_W] <= bus.upd_data;
                mem[bus.upd_tag][1]                <= 1'b1;
            end
            if (commit_fire) begin
                mem[head][1:0] <= 2'b00;
                head           <= head + AW'(1);
            end
            if (alloc_fire) begin
                mem[tail] <= {bus.alloc_data[ENTRY_W-1:2], 2'b01};
                tail      <= tail + AW'(1);
            end
            count_q <= count_q + (AW+1)'(alloc_fire) - (AW+1)'(commit_fire);
        end
    end

    assign bus.alloc_ready  = ~full_w;
    assign bus.alloc_tag    = tail;
    assign bus.commit_valid = head_ready;
    assign bus.commit_tag   = head;
    assign bus.commit_data  = head_entry;
    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = (count_q == '0);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]      tag;
        logic [ENTRY_W-1:0] word;

        assign tag = bus.rd_tag[k*AW +: AW];

`ifdef TMPRF_BYPASS_EN
        // Forward a same-cycle CDB result into the operand lookup.
        always_comb begin
            word = mem[tag];
            if (upd_fire && (bus.upd_tag == tag)) begin
                word[SD_LSB +: DATA_W] = bus.upd_data;
                word[1]                = 1'b1;
            end
        end
`else
        assign word = mem[tag];
`endif

        assign bus.rd_data[k*ENTRY_W +: ENTRY_W] = word;
    end
endmodule

// File: tb/tb_tmp_regfile_rob.sv
// tb/tb_tmp_regfile_rob.sv - randomized bench with field-level reference model for tmp_regfile_rob
module tb_tmp_regfile_rob;
    localparam int DEPTH   = 32;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 32;
    localparam int REG_W   = 5;
    localparam int NRD     = 2;
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = REG_W + PC_W + 2 + DATA_W + 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    tmp_regfile_rob_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W),
                         .REG_W(REG_W), .NRD(NRD)) bus ();

    tmp_regfile_rob #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W),
                      .REG_W(REG_W), .NRD(NRD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one record per slot, kept as separate fields.
    logic [REG_W-1:0]  m_rd [DEPTH];
    logic [PC_W-1:0]   m_pc [DEPTH];
    logic [1:0]        m_ty [DEPTH];
    logic [DATA_W-1:0] m_sd [DEPTH];
    bit                m_sv [DEPTH];
    bit                m_v  [DEPTH];
    int                m_head, m_tail, m_cnt;

    function automatic logic [ENTRY_W-1:0] m_entry(input int t);
        return {m_rd[t], m_pc[t], m_ty[t], m_sd[t], m_sv[t], m_v[t]};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_rd[i] = '0; m_pc[i] = '0; m_ty[i] = '0; m_sd[i] = '0;
            m_sv[i] = 0;  m_v[i]  = 0;
        end
        m_head = 0; m_tail = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        int t;
        bit u;
        logic [DATA_W-1:0] sd;
        bit sv;
        check("alloc_ready",  bus.alloc_ready,  m_cnt < DEPTH);
        check("alloc_tag",    bus.alloc_tag,    m_tail);
        check("commit_valid", bus.commit_valid, m_v[m_head] && m_sv[m_head]);
        check("commit_tag",   bus.commit_tag,   m_head);
        check("commit_data",  bus.commit_data,  m_entry(m_head));
        check("count",        bus.count,        m_cnt);
        check("full",         bus.full,         m_cnt == DEPTH);
        check("empty",        bus.empty,        m_cnt == 0);
        u = bus.upd_valid && m_v[int'(bus.upd_tag)];
        for (int k = 0; k < NRD; k++) begin
            t  = int'(bus.rd_tag[k*AW +: AW]);
            sd = m_sd[t];
            sv = m_sv[t];
`ifdef TMPRF_BYPASS_EN
            if (u && t == int'(bus.upd_tag)) begin
                sd = bus.upd_data;
                sv = 1;
            end
`endif
            check($sformatf("rd_data%0d", k), bus.rd_data[k*ENTRY_W +: ENTRY_W],
                  {m_rd[t], m_pc[t], m_ty[t], sd, sv, m_v[t]});
        end
    endtask

    task automatic model_next();
        bit a, c, u;
        int ut;
        if (bus.flush) begin
            m_clear();
            return;
        end
        a  = bus.alloc_valid && (m_cnt < DEPTH);
        c  = bus.commit_ready && m_v[m_head] && m_sv[m_head];
        ut = int'(bus.upd_tag);
        u  = bus.upd_valid && m_v[ut];
        if (u) begin
            m_sd[ut] = bus.upd_data;
            m_sv[ut] = 1;
        end
        if (c) begin
            m_v[m_head]  = 0;
            m_sv[m_head] = 0;
            m_head = (m_head + 1) % DEPTH;
        end
        if (a) begin
            m_rd[m_tail] = bus.alloc_data[ENTRY_W-1 -: REG_W];
            m_pc[m_tail] = bus.alloc_data[DATA_W+4 +: PC_W];
            m_ty[m_tail] = bus.alloc_data[DATA_W+2 +: 2];
            m_sd[m_tail] = bus.alloc_data[2 +: DATA_W];
            m_sv[m_tail] = 0;
            m_v[m_tail]  = 1;
            m_tail = (m_tail + 1) % DEPTH;
        end
        m_cnt = m_cnt + int'(a) - int'(c);
    endtask

    // Inputs are set just after a falling edge; this checks, advances the model and clocks once.
    task automatic cycle();
        #1;
        check_outputs();
        model_next();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.alloc_valid  = 1'b0;
        bus.alloc_data   = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_tag      = '0;
        bus.upd_data     = '0;
        bus.commit_ready = 1'b0;
    endtask

    function automatic logic [ENTRY_W-1:0] rand_entry();
        return ENTRY_W'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [NRD*AW-1:0] rand_tags();
        return (NRD*AW)'($urandom());
    endfunction

    task automatic do_flush();
        idle();
        bus.flush = 1'b1;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        bus.rd_tag = '0;
        reset = 1'b1;
        m_clear();
        @(negedge clock);
        #1;
        check_outputs();
        reset = 1'b0;
        @(negedge clock);

        // Three allocations with rd_reg 1,2,3; low alloc_data bits set to show they are ignored.
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.alloc_valid = 1'b1;
            bus.alloc_data  = {REG_W'(i + 1), PC_W'(32'h100 + 4 * i), 2'(i), DATA_W'(0), 2'b11};
            bus.rd_tag      = {AW'(1), AW'(0)};
            cycle();
        end
        idle();
        cycle();

        // Result for tag 0 then commit.
        bus.upd_valid    = 1'b1;
        bus.upd_tag      = '0;
        bus.upd_data     = 32'hDEADBEEF;
        bus.commit_ready = 1'b1;
        cycle();
        bus.upd_valid = 1'b0;
        cycle();
        cycle();

        // Fill to full, try a 33rd alloc, then alloc+commit at full.
        do_flush();
        for (int i = 0; i < DEPTH + 1; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_data  = rand_entry();
            bus.rd_tag      = rand_tags();
            cycle();
        end
        idle();
        bus.upd_valid = 1'b1;
        bus.upd_tag   = '0;
        bus.upd_data  = $urandom();
        cycle();
        idle();
        bus.alloc_valid  = 1'b1;
        bus.alloc_data   = rand_entry();
        bus.commit_ready = 1'b1;
        cycle();
        idle();
        cycle();

        // Back-to-back alloc/update/commit across the pointer wrap.
        do_flush();
        for (int i = 0; i < 40; i++) begin
            bus.alloc_valid  = 1'b1;
            bus.alloc_data   = rand_entry();
            bus.upd_valid    = (m_cnt > 0);
            bus.upd_tag      = AW'((m_tail + DEPTH - 1) % DEPTH);
            bus.upd_data     = $urandom();
            bus.commit_ready = 1'b1;
            bus.rd_tag       = {AW'(m_head), AW'((m_tail + DEPTH - 1) % DEPTH)};
            cycle();
        end
        idle();
        cycle();
        cycle();

        // Read of a tag in the same cycle as its update, then update of a dead tag.
        do_flush();
        for (int i = 0; i < 6; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_data  = rand_entry();
            cycle();
        end
        idle();
        bus.rd_tag    = {AW'(7), AW'(5)};
        bus.upd_valid = 1'b1;
        bus.upd_tag   = AW'(5);
        bus.upd_data  = 32'hCAFEF00D;
        cycle();
        idle();
        cycle();
        bus.upd_valid = 1'b1;
        bus.upd_tag   = AW'(7);
        bus.upd_data  = 32'h12345678;
        cycle();
        idle();
        cycle();

        // Flush with ten live entries while an alloc and commit are also requested.
        do_flush();
        for (int i = 0; i < 10; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_data  = rand_entry();
            bus.upd_valid   = (i > 0);
            bus.upd_tag     = AW'((m_tail + DEPTH - 1) % DEPTH);
            bus.upd_data    = $urandom();
            cycle();
        end
        idle();
        bus.flush        = 1'b1;
        bus.alloc_valid  = 1'b1;
        bus.alloc_data   = rand_entry();
        bus.commit_ready = 1'b1;
        cycle();
        idle();
        bus.rd_tag = {AW'(3), AW'(9)};
        cycle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            bus.flush        = ($urandom_range(0, 99) == 0);
            bus.alloc_valid  = ($urandom_range(0, 99) < 60);
            bus.alloc_data   = rand_entry();
            bus.upd_valid    = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 3) != 0 && m_cnt > 0)
                bus.upd_tag = AW'((m_head + int'($urandom_range(0, m_cnt - 1))) % DEPTH);
            else
                bus.upd_tag = AW'($urandom());
            bus.upd_data     = $urandom();
            bus.commit_ready = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 1) == 1)
                bus.rd_tag = {AW'($urandom()), bus.upd_tag};
            else
                bus.rd_tag = rand_tags();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
